// File: rtl/mem_return_pkg.sv
// -----------------------------------------------------------------------------
// mem_return_pkg
//   Shared types for the memory-return router: the kind of load a read was
//   issued for, the tag that follows each read through the fixed-latency
//   memory port, and the number of data-cursor (DC) cache slots.
// -----------------------------------------------------------------------------
package mem_return_pkg;

    localparam int NUM_DCS = 4;
    localparam int SLOT_W  = $clog2(NUM_DCS);

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        DSTACK = 2'd1,
        CONV   = 2'd2,
        RELOAD = 2'd3
    } load_kind_t;

    typedef struct packed {
        logic              valid;
        load_kind_t        kind;
        logic [SLOT_W-1:0] slot;
    } load_tag_t;

    localparam load_tag_t TAG_NONE = '{valid: 1'b0, kind: NONE, slot: '0};

endpackage

// File: rtl/mem_tag_pipe.sv
// -----------------------------------------------------------------------------
// mem_tag_pipe
//   READ_LATENCY-deep shift register of load tags. Stage 0 captures the tag of
//   the read issued this cycle; the entry in the last stage is the one whose
//   data is on the memory read port this cycle.
//   Entries can be killed while in flight:
//     - flush_i kills every CONV entry (including the one being issued);
//     - kill_en_i kills every RELOAD entry for kill_slot_i (older refills of a
//       slot that is being reloaded again).
//   The kills also apply to the returning entry, so a return that coincides
//   with a kill is dropped.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   flush_i       kill in-flight conveyor loads
//   kill_en_i     a RELOAD is being issued this cycle
//   kill_slot_i   slot of that RELOAD
//   tag_i         tag of the read issued this cycle
//   ret_tag_o     tag paired with this cycle's memory read data
// -----------------------------------------------------------------------------
module mem_tag_pipe
    import mem_return_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              kill_en_i,
    input  logic [SLOT_W-1:0] kill_slot_i,
    input  load_tag_t         tag_i,
    output load_tag_t         ret_tag_o
);

    load_tag_t stage_q [READ_LATENCY];
    load_tag_t stage_d [READ_LATENCY];

    function automatic load_tag_t apply_kill(input load_tag_t         t,
                                             input logic              fl,
                                             input logic              ken,
                                             input logic [SLOT_W-1:0] ks);
        load_tag_t r;
        r = t;
        if (t.valid && ((fl && t.kind == CONV) ||
                        (ken && t.kind == RELOAD && t.slot == ks))) begin
            r = TAG_NONE;
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every stage gets a value on every path, so no latch is inferred.
        // The new RELOAD must not kill itself, so only flush applies to stage 0.
        stage_d[0] = (tag_i.valid && flush_i && tag_i.kind == CONV) ? TAG_NONE : tag_i;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_d[i] = apply_kill(stage_q[i-1], flush_i, kill_en_i, kill_slot_i);
        end
    end

    assign ret_tag_o = apply_kill(stage_q[READ_LATENCY-1], flush_i, kill_en_i, kill_slot_i);

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of its predecessor. The array is small control state,
    // so it is reset outright to drop any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/mem_return_router.sv
// -----------------------------------------------------------------------------
// mem_return_router
//   Tracks every read the memory controller issues to the fixed-latency main
//   memory port and routes the returned word to the data stack, the conveyor,
//   or one of the DC cache slots. Also drives the *_memload_last feedback used
//   upstream to block back-to-back loads, and a stall when a slot the current
//   instruction needs is not present.
//
//   Build option: define MEM_RETURN_DC_FORWARD_EN to forward a returning DC
//   refill to dc_values/dc_valid (and hence stall) in the return cycle itself.
//   Without it the refill is visible one cycle later, from the registers.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   issue_dstack/_conveyor/_reload  read issued this cycle, by destination
//   issue_choice            DC slot refilled by issue_reload
//   flush                   interrupt taken: drop in-flight conveyor loads
//   mem_read_value          memory data, READ_LATENCY cycles after issue
//   conveyor_memload_last   issue_conveyor delayed one cycle
//   dstack_memload_last     issue_dstack delayed one cycle
//   dstack_push/_value      data-stack push strobe and word
//   conveyor_valid/_value   conveyor strobe and word
//   dc_values/dc_valid      cached word and presence per DC slot
//   need_dc                 slots the current instruction reads
//   stall                   a needed slot is not present
//   issue_error             sticky: two or more issue_* in one cycle
// -----------------------------------------------------------------------------
module mem_return_router
    import mem_return_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 issue_dstack,
    input  logic                                 issue_conveyor,
    input  logic                                 issue_reload,
    input  logic [SLOT_W-1:0]                    issue_choice,
    input  logic                                 flush,
    input  logic [WORD_WIDTH-1:0]                mem_read_value,
    output logic                                 conveyor_memload_last,
    output logic                                 dstack_memload_last,
    output logic                                 dstack_push,
    output logic [WORD_WIDTH-1:0]                dstack_value,
    output logic                                 conveyor_valid,
    output logic [WORD_WIDTH-1:0]                conveyor_value,
    output logic [NUM_DCS-1:0][WORD_WIDTH-1:0]   dc_values,
    output logic [NUM_DCS-1:0]                   dc_valid,
    input  logic [NUM_DCS-1:0]                   need_dc,
    output logic                                 stall,
    output logic                                 issue_error
);

    load_tag_t  issue_tag;
    load_tag_t  ret_tag;
    logic [1:0] issue_count;
    logic       multi_issue;
    logic       reload_issue;
    logic       ret_live;
    logic       ret_reload;

    logic                               dstack_last_q, conveyor_last_q;
    logic                               issue_error_q;
    logic [NUM_DCS-1:0]                 dc_valid_q, dc_valid_d;
    logic [NUM_DCS-1:0][WORD_WIDTH-1:0] dc_values_q, dc_values_d;

    // Priority reload > dstack > conveyor; only the winner is tracked.
    always_comb begin
        issue_tag = TAG_NONE;
        if (issue_reload) begin
            issue_tag = '{valid: 1'b1, kind: RELOAD, slot: issue_choice};
        end else if (issue_dstack) begin
            issue_tag = '{valid: 1'b1, kind: DSTACK, slot: '0};
        end else if (issue_conveyor) begin
            issue_tag = '{valid: 1'b1, kind: CONV, slot: '0};
        end
    end

    assign issue_count  = 2'(issue_reload) + 2'(issue_dstack) + 2'(issue_conveyor);
    assign multi_issue  = issue_count > 2'd1;
    assign reload_issue = issue_tag.valid && issue_tag.kind == RELOAD;

    mem_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .kill_en_i   (reload_issue),
        .kill_slot_i (issue_choice),
        .tag_i       (issue_tag),
        .ret_tag_o   (ret_tag)
    );

    // Strobes are held low during the reset cycle even if a tag is still
    // sitting in the pipe before the reset edge clears it.
    assign ret_live   = ret_tag.valid && !reset;
    assign ret_reload = ret_live && ret_tag.kind == RELOAD;

    assign dstack_push    = ret_live && ret_tag.kind == DSTACK;
    assign dstack_value   = mem_read_value;
    assign conveyor_valid = ret_live && ret_tag.kind == CONV;
    assign conveyor_value = mem_read_value;

    // A refill landing and a new reload of the same slot cannot both be live:
    // the pipe already dropped the older return, so the order here only
    // matters for different slots, where both take effect.
    always_comb begin
        dc_valid_d  = dc_valid_q;
        dc_values_d = dc_values_q;
        if (ret_reload) begin
            dc_values_d[ret_tag.slot] = mem_read_value;
            dc_valid_d[ret_tag.slot]  = 1'b1;
        end
        if (reload_issue) begin
            dc_valid_d[issue_choice] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc_valid_q      <= '0;
            dc_values_q     <= '0;
            dstack_last_q   <= 1'b0;
            conveyor_last_q <= 1'b0;
            issue_error_q   <= 1'b0;
        end else begin
            dc_valid_q      <= dc_valid_d;
            dc_values_q     <= dc_values_d;
            dstack_last_q   <= issue_dstack;
            conveyor_last_q <= issue_conveyor;
            issue_error_q   <= issue_error_q | multi_issue;
        end
    end

`ifdef MEM_RETURN_DC_FORWARD_EN
    always_comb begin
        dc_valid  = dc_valid_q;
        dc_values = dc_values_q;
        if (ret_reload) begin
            dc_values[ret_tag.slot] = mem_read_value;
            dc_valid[ret_tag.slot]  = 1'b1;
        end
    end
`else
    assign dc_valid  = dc_valid_q;
    assign dc_values = dc_values_q;
`endif

    assign stall                 = |(need_dc & ~dc_valid);
    assign dstack_memload_last   = dstack_last_q;
    assign conveyor_memload_last = conveyor_last_q;
    assign issue_error           = issue_error_q;

endmodule
